// File: rtl/byte_mem_pkg.sv
// Shared types for the byte-wide load/store sequencer.
package byte_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Number of RAM bytes touched by an access of the given size.
  // The illegal size is rejected elsewhere, so its count only has to be harmless.
  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_mem_sequencer_if.sv
// Request/response and RAM port bundle of the byte sequencer.
// slave  : the sequencer itself (takes requests, drives the RAM port).
// master : its environment (the core issuing requests plus the RAM array).
interface byte_mem_sequencer_if
  import byte_mem_pkg::*;
#(parameter int ADDR_W = 9);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  size_e             req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/byte_mem_sequencer_load_extend.sv
// Sign/zero extension of the assembled little-endian load buffer.
module load_extend
  import byte_mem_pkg::*;
(
  input  logic [31:0] rbuf_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Replicate the top bit of the loaded width unless zero fill is requested
  always_comb begin
    data_o = rbuf_i;
    case (size_i)
      SZ_B:    data_o = {{24{rbuf_i[7] & ~unsigned_i}}, rbuf_i[7:0]};
      SZ_H:    data_o = {{16{rbuf_i[15] & ~unsigned_i}}, rbuf_i[15:0]};
      default: data_o = rbuf_i;
    endcase
  end

endmodule

// File: rtl/byte_mem_sequencer.sv
// Load/store sequencer: splits one byte/half/word request into little-endian
// single-byte RAM accesses and returns one response.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests are
// rejected with resp_err instead of being sequenced byte by byte.
module byte_mem_sequencer
  import byte_mem_pkg::*;
#(parameter int ADDR_W = 9)
(
  input  logic                 clk,
  input  logic                 rst,
  byte_mem_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic              live_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              we_q, uns_q, err_q;
  size_e             size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              req_err;
  logic [ADDR_W:0]   last_addr;
  logic [1:0]        last_idx;
  logic [1:0]        cap_idx;
  logic [31:0]       ext_data;

  assign accept   = bus.req_valid && bus.req_ready;
  assign last_idx = 2'(size_bytes(size_q) - 3'd1);
  assign cap_idx  = cnt_q - 2'd1;

  // Classify an incoming request; the extra top bit of last_addr flags running off the end
  always_comb begin
    last_addr = {1'b0, bus.req_addr[ADDR_W-1:0]}
              + (ADDR_W+1)'(size_bytes(bus.req_size) - 3'd1);
    req_err   = (bus.req_size == SZ_BAD) || (|bus.req_addr[31:ADDR_W]) || last_addr[ADDR_W];
`ifdef MISALIGN_TRAP_EN
    if ((bus.req_size == SZ_H && bus.req_addr[0]) ||
        (bus.req_size == SZ_W && (|bus.req_addr[1:0])))
      req_err = 1'b1;
`else
`endif
  end

  // State, byte counter, read buffer and the latched request
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every flop here is reset, the read buffer included; it is a handful of
    // register bits, not a RAM, so clearing it costs nothing and keeps resp_rdata defined.
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      base_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      live_q  <= 1'b1;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
        size_q  <= bus.req_size;
        base_q  <= bus.req_addr[ADDR_W-1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Next state, byte counter and read-buffer capture
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          rbuf_d  = '0;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // Read data lags its issue by one cycle, so this cycle returns byte cnt-1
        if (!we_q && cnt_q != 2'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_rdata;
        if (cnt_q == last_idx) state_d = we_q ? RESP : CAPTURE;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      CAPTURE: begin
        rbuf_d[{last_idx, 3'b000} +: 8] = bus.ram_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .rbuf_i     (rbuf_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  // Outputs decoded from state and latched request only; nothing flows from req_* to ram_*
  always_comb begin
    bus.req_ready  = live_q && (state_q == IDLE);
    bus.ram_en     = 1'b0;
    bus.ram_we     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    if (state_q == ACCESS) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = we_q;
      bus.ram_addr  = base_q + ADDR_W'(cnt_q);
      bus.ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    end
    if (state_q == RESP) begin
      bus.resp_valid = 1'b1;
      bus.resp_err   = err_q;
      if (!err_q && !we_q) bus.resp_rdata = ext_data;
    end
  end

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Self-checking bench for byte_mem_sequencer: directed cases plus randomized
// requests checked against a byte-array reference model.
module tb_byte_mem_sequencer;
  import byte_mem_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  byte_mem_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  byte_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM array behind the sequencer: synchronous write, registered read
  logic [7:0] ram     [DEPTH] = '{default: 8'h00};
  logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  time last_accept;

  // Observed RAM accesses of the current request (cycle index counted from accept)
  int                acc_cyc  [$];
  logic [ADDR_W-1:0] acc_addr [$];
  logic              acc_we   [$];
  logic [7:0]        acc_wd   [$];

  // Reference model: legality, latency, byte count and load result from plain arithmetic
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic e_err, output logic [31:0] e_rd,
                                output int e_lat, output int e_n);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = '0;
    e_err = (sz == 2'd3) || (addr >= 32'(DEPTH)) || (addr + 32'(n) > 32'(DEPTH));
`ifdef MISALIGN_TRAP_EN
    if (n > 1 && (addr % 32'(n)) != 0) e_err = 1'b1;
`endif
    e_rd = '0;
    e_n  = 0;
    if (e_err) begin
      e_lat = 1;
    end else begin
      e_n   = n;
      e_lat = we ? n + 1 : n + 2;
      for (int k = 0; k < n; k++) begin
        if (we) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
        else    v[8*k +: 8] = ref_mem[addr + 32'(k)];
      end
      if (!we) begin
        if (!uns && n == 1 && v[7])  v[31:8]  = '1;
        if (!uns && n == 2 && v[15]) v[31:16] = '1;
        e_rd = v;
      end
    end
  endfunction

  // Drive one request and watch up to 20 cycles for its response
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
    acc_cyc.delete(); acc_addr.delete(); acc_we.delete(); acc_wd.delete();
    lat = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size_e'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    last_accept = $time;
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        acc_cyc.push_back(c);
        acc_addr.push_back(bus.ram_addr);
        acc_we.push_back(bus.ram_we);
        acc_wd.push_back(bus.ram_wdata);
      end
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_en,
         bus.ram_we, bus.ram_addr, bus.ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rv=%b re=%b rd=%h en=%b we=%b a=%h wd=%h exp all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_en,
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    rst = 1'b1;
    #1 checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_at_release got=%b exp=0", bus.req_ready);
    end
    @(posedge clk); #1 checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge got=%b exp=1", bus.req_ready);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_n;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [8];
    int lat, e_lat, e_n;
    logic [31:0] rd, e_rd;
    logic er, e_err;
    tbl = '{
      '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 5, 4},
      '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 6, 4},
      '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 1},
      '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'h000000DE, 1'b0, 3, 1},
      '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 4, 2},
      '{1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0,        32'h00000000, 1'b1, 1, 0},
      '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,        32'h00000000, 1'b1, 1, 0},
      '{1'b1, 2'd3, 1'b0, 32'h000, 32'h12345678, 32'h00000000, 1'b1, 1, 0}
    };
    for (int i = 0; i < 8; i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, e_err, e_rd, e_lat, e_n);
      run_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, lat, rd, er);
      checks++;
      if (rd !== tbl[i].exp_rd || er !== tbl[i].exp_err || lat !== tbl[i].exp_lat ||
          acc_cyc.size() !== tbl[i].exp_n) begin
        errors++;
        $display("FAIL directed_%0d rd=%h err=%b lat=%0d nacc=%0d exp rd=%h err=%b lat=%0d nacc=%0d",
                 i, rd, er, lat, acc_cyc.size(), tbl[i].exp_rd, tbl[i].exp_err,
                 tbl[i].exp_lat, tbl[i].exp_n);
      end
      if (i == 0) begin
        for (int k = 0; k < 4 && k < acc_cyc.size(); k++) begin
          checks++;
          if (acc_cyc[k] !== k + 1 || acc_addr[k] !== ADDR_W'(16 + k) || acc_we[k] !== 1'b1 ||
              acc_wd[k] !== tbl[0].wd[8*k +: 8]) begin
            errors++;
            $display("FAIL store_byte_%0d cyc=%0d addr=%h we=%b wd=%h exp cyc=%0d addr=%h we=1 wd=%h",
                     k, acc_cyc[k], acc_addr[k], acc_we[k], acc_wd[k], k + 1, 16 + k,
                     tbl[0].wd[8*k +: 8]);
          end
        end
      end
    end
  endtask

  task automatic test_misalign();
    int lat, e_lat, e_n;
    logic [31:0] rd, e_rd;
    logic er, e_err;
    model(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, e_err, e_rd, e_lat, e_n);
    run_req(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, lat, rd, er);
    checks++;
`ifdef MISALIGN_TRAP_EN
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || acc_cyc.size() !== 0) begin
      errors++;
      $display("FAIL misalign_trap err=%b rd=%h lat=%0d nacc=%0d exp err=1 rd=0 lat=1 nacc=0",
               er, rd, lat, acc_cyc.size());
    end
`else
    if (er !== 1'b0 || rd !== 32'hFFFFADBE || lat !== 4 || acc_cyc.size() !== 2 ||
        acc_addr[0] !== 9'h011 || acc_addr[1] !== 9'h012) begin
      errors++;
      $display("FAIL misalign_half err=%b rd=%h lat=%0d nacc=%0d exp err=0 rd=ffffadbe lat=4 nacc=2 at 011/012",
               er, rd, lat, acc_cyc.size());
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    logic er;
    time t_prev;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, lat, rd, er);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 6) begin
        errors++;
        $display("FAIL b2b_load_%0d rd=%h err=%b lat=%0d exp deadbeef 0 6", i, rd, er, lat);
      end
      if (i > 0) begin
        checks++;
        if (last_accept - t_prev !== 70) begin
          errors++;
          $display("FAIL b2b_spacing_%0d got=%0t exp=70", i, last_accept - t_prev);
        end
      end
      t_prev = last_accept;
    end
    @(negedge clk); checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse rv=%b ready=%b exp rv=0 ready=1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd, wd;
    logic er;
    bit seen;
    wd = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = wd;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 9'h102 ||
        bus.ram_wdata !== wd[23:16]) begin
      errors++;
      $display("FAIL third_byte en=%b we=%b addr=%h wd=%h exp 1 1 102 %h",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, wd[23:16]);
    end
    rst = 1'b0;
    #1 checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_en,
         bus.ram_we, bus.ram_addr, bus.ram_wdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs ready=%b rv=%b en=%b we=%b a=%h wd=%h exp all 0",
               bus.req_ready, bus.resp_valid, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    // The first two bytes made it into the RAM before the abort
    ref_mem[9'h100] = wd[7:0];
    ref_mem[9'h101] = wd[15:8];
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || bus.ram_en) seen = 1'b1;
    end
    rst = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got=%b exp=0", seen);
    end
    #1 checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready_release got=%b exp=0", bus.req_ready);
    end
    @(posedge clk); #1 checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready_edge got=%b exp=1", bus.req_ready);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h0000F00D || er !== 1'b0 || lat !== 6) begin
      errors++;
      $display("FAIL after_abort_load rd=%h err=%b lat=%0d exp 0000f00d 0 6", rd, er, lat);
    end
  endtask

  task automatic test_random();
    int lat, e_lat, e_n, bad, r;
    logic [31:0] rd, e_rd, addr, wd;
    logic [1:0] sz;
    logic er, e_err, we, uns;
    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r   = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'(DEPTH - $urandom_range(1, 3));
      else if (r < 7)  addr = 32'($urandom_range(0, 63));
      else             addr = 32'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      model(we, sz, uns, addr, wd, e_err, e_rd, e_lat, e_n);
      run_req(we, sz, uns, addr, wd, lat, rd, er);
      checks++;
      if (er !== e_err || rd !== e_rd || lat !== e_lat || acc_cyc.size() !== e_n) begin
        errors++;
        $display("FAIL rand_%0d we=%b sz=%0d a=%h rd=%h err=%b lat=%0d nacc=%0d exp rd=%h err=%b lat=%0d nacc=%0d",
                 i, we, sz, addr, rd, er, lat, acc_cyc.size(), e_rd, e_err, e_lat, e_n);
      end
      bad = 0;
      for (int k = 0; k < acc_cyc.size(); k++) begin
        if (acc_cyc[k] !== k + 1 || acc_addr[k] !== ADDR_W'(addr + 32'(k)) || acc_we[k] !== we ||
            (we && acc_wd[k] !== wd[8*k +: 8]))
          bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rand_trace_%0d bad_accesses=%0d exp=0", i, bad);
      end
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    test_reset();
    test_directed();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_mem_sequencer.md
# byte_mem_sequencer

Load/store sequencer that sits directly upstream of the byte-wide RAM array and is its only master. It accepts one 32-bit load or store request at a time (byte, half or word), breaks it into little-endian single-byte RAM accesses, and returns a single response with sign- or zero-extended read data or an error flag. It converts core-side word traffic into the 8-bit-wide storage port.

## Interface
- ADDR_W, 9, RAM byte-address width (2^ADDR_W bytes; default 512).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; a transfer occurs when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, in the low bytes.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no RAM access performed.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write, qualified by ram_en.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; valid the cycle after a read issue.

## Operation
- Number of bytes n: 1, 2 or 4 from req_size. Byte k of the access uses address req_addr+k and bits [8k+7:8k] (little-endian).
- Error on accept:
  - req_size==3, or
  - req_addr[31:ADDR_W] != 0, or
  - req_addr[ADDR_W-1:0]+n-1 > 2^ADDR_W-1 (no wrap-around).
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
  - IDLE: req_ready=1. On accept, latch the request, set cnt=0, then go to RESP if there is an error, otherwise to ACCESS.
  - ACCESS: ram_en=1, ram_we=req_we, ram_addr=base+cnt, ram_wdata=wdata byte cnt. For a load, capture ram_rdata into byte cnt-1 of the read buffer when cnt>0. When cnt==n-1, a store goes to RESP and a load goes to CAPTURE; otherwise cnt++.
  - CAPTURE: capture the final byte into byte n-1; go to RESP.
  - RESP: resp_valid=1 and resp_rdata/resp_err driven; go to IDLE.
- Extension:
  - byte: sign bit 7;
  - half: sign bit 15;
  - word: no extension;
  - req_unsigned forces zero fill.
- req_ready=0 in every non-IDLE state. The block serves one request at a time.
- Outside ACCESS, ram_en=0 and ram_we=0.

## Timing
- Reset values (asserted asynchronously): state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- req_ready rises on the first rising edge after rst deasserts.
- Accept at edge T. RAM accesses occur in cycles T+1..T+n.
  - Store: resp_valid at T+n+1.
  - Load: resp_valid at T+n+2.
  - Error: resp_valid at T+1.
- Next accept is possible the edge after RESP. Word-load throughput is 1 per 7 cycles.
- All outputs are registered or decoded only from state and latched registers; there is no combinational path from req_* to ram_*.
- Reset asserted mid-request aborts it immediately. Bytes already written remain written, and no response is issued.

## Configuration
- MISALIGN_TRAP_EN defined: a half with req_addr[0]!=0, or a word with req_addr[1:0]!=0, is an error (resp_err, no RAM access).
- Undefined: misaligned accesses are legal and sequenced byte by byte like aligned ones; only the range and size errors apply.

## Structure
- Shared package byte_mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_BAD;
  - state enum;
  - function returning n from the size.
- One sub-module, load_extend: purely combinational; takes the 32-bit buffer, size and unsigned flag and produces the extended 32-bit result.

## Test plan
- Reset then word store 0xDEADBEEF at 0x010 -> bytes EF,BE,AD,DE written at 0x010..0x013 on 4 consecutive cycles; resp_valid 5 cycles after accept, resp_err=0.
- Word load at 0x010 -> resp_rdata=0xDEADBEEF 6 cycles after accept.
- Byte load at 0x013: signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Half signed at 0x012 -> 0xFFFFDEAD.
- Word access at 0x1FE, or req_addr=0x200, or req_size=3 -> resp_err=1, resp_rdata=0, ram_en never asserted, response 1 cycle after accept.
- Half at 0x011:
  - with MISALIGN_TRAP_EN -> resp_err=1;
  - without it -> bytes at 0x011/0x012 accessed, correct data returned.
- rst low during the third byte of a word store -> outputs return to reset values at once, no resp_valid. req_ready returns one edge after release, and a following load completes normally.
